// File: rtl/prf_reclaim_unit_if.sv
// Commit-side and freelist-side signal bundle for prf_reclaim_unit.
// The master modport is the environment (ROB commit plus freelist). The slave modport is the reclaim unit.
interface prf_reclaim_unit_if #(
    parameter int PRF_ADDR_WIDTH  = 5,
    parameter int BUF_DEPTH_WIDTH = 2
);
    logic                       commit_first_valid_i;
    logic                       commit_first_rd_en_i;
    logic [PRF_ADDR_WIDTH-1:0]  commit_first_old_prd_i;
    logic                       commit_second_valid_i;
    logic                       commit_second_rd_en_i;
    logic [PRF_ADDR_WIDTH-1:0]  commit_second_old_prd_i;
    logic                       commit_ready_o;
    logic                       fl_wr_stall_i;
    logic                       fl_wr_first_en_o;
    logic                       fl_wr_second_en_o;
    logic [PRF_ADDR_WIDTH-1:0]  fl_wdata_first_o;
    logic [PRF_ADDR_WIDTH-1:0]  fl_wdata_second_o;
    logic                       fl_rd_excep_first_en_o;
    logic                       fl_rd_excep_second_en_o;
    logic [BUF_DEPTH_WIDTH:0]   buf_num_o;
    logic                       buf_empty_o;

    // Handshake: a commit slot transfers on a clock edge when its valid and commit_ready_o are both high.
    // ready depends only on registered occupancy. The second slot is legal only together with the first.
    // The freelist write has no ready signal. It fires whenever an enable is high, and the stall input blocks it.
    modport master (
        output commit_first_valid_i, commit_first_rd_en_i, commit_first_old_prd_i,
        output commit_second_valid_i, commit_second_rd_en_i, commit_second_old_prd_i,
        output fl_wr_stall_i,
        input  commit_ready_o, fl_wr_first_en_o, fl_wr_second_en_o,
        input  fl_wdata_first_o, fl_wdata_second_o,
        input  fl_rd_excep_first_en_o, fl_rd_excep_second_en_o,
        input  buf_num_o, buf_empty_o
    );

    modport slave (
        input  commit_first_valid_i, commit_first_rd_en_i, commit_first_old_prd_i,
        input  commit_second_valid_i, commit_second_rd_en_i, commit_second_old_prd_i,
        input  fl_wr_stall_i,
        output commit_ready_o, fl_wr_first_en_o, fl_wr_second_en_o,
        output fl_wdata_first_o, fl_wdata_second_o,
        output fl_rd_excep_first_en_o, fl_rd_excep_second_en_o,
        output buf_num_o, buf_empty_o
    );
endinterface

// File: rtl/prf_reclaim_unit.sv
// Returns stale physical registers from retiring instructions to the freelist in program order.
// It also advances the freelist's committed allocation pointer.
module prf_reclaim_unit #(
    parameter int PRF_ADDR_WIDTH  = 5,
    parameter int BUF_DEPTH       = 4,
    parameter int BUF_DEPTH_WIDTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    prf_reclaim_unit_if.slave port
);
    localparam logic [BUF_DEPTH_WIDTH:0] DEPTH = (BUF_DEPTH_WIDTH+1)'(BUF_DEPTH);
    localparam logic [BUF_DEPTH_WIDTH:0] TWO   = (BUF_DEPTH_WIDTH+1)'(2);

    logic [PRF_ADDR_WIDTH-1:0]  entry_q [BUF_DEPTH];
    logic [BUF_DEPTH_WIDTH-1:0] head_q, tail_q;
    logic [BUF_DEPTH_WIDTH:0]   num_q, num_next;
    logic                       excep_first_q, excep_second_q;

    logic ready;
    logic acc_first, acc_second;
    logic alloc_first, alloc_second;
    logic push_first, push_second;
    logic pop_first, pop_second;
    logic [1:0] push_cnt, pop_cnt;
    logic [BUF_DEPTH_WIDTH-1:0] second_slot, head_plus1;

    assign ready = (DEPTH - num_q) >= TWO;

    // A second slot without the first is ignored, so the younger slot is never accepted on its own.
    assign acc_first    = port.commit_first_valid_i & ready;
    assign acc_second   = acc_first & port.commit_second_valid_i;
    assign alloc_first  = acc_first  & port.commit_first_rd_en_i;
    assign alloc_second = acc_second & port.commit_second_rd_en_i;

    // p0 is hardwired and is never returned to the freelist.
    assign push_first  = alloc_first  & (port.commit_first_old_prd_i  != '0);
    assign push_second = alloc_second & (port.commit_second_old_prd_i != '0);
    assign push_cnt    = {push_first & push_second, push_first ^ push_second};

    assign pop_first  = ~port.fl_wr_stall_i & (num_q != '0);
    assign pop_second = ~port.fl_wr_stall_i & (num_q >= TWO);
    assign pop_cnt    = {pop_second, pop_first & ~pop_second};

    // When only the younger slot qualifies, it takes the tail slot. This keeps the buffer gap-free.
    assign second_slot = tail_q + BUF_DEPTH_WIDTH'(push_first);
    assign head_plus1  = head_q + BUF_DEPTH_WIDTH'(1);
    assign num_next    = num_q + (BUF_DEPTH_WIDTH+1)'(push_cnt) - (BUF_DEPTH_WIDTH+1)'(pop_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            num_q          <= '0;
            excep_first_q  <= 1'b0;
            excep_second_q <= 1'b0;
        end else begin
            head_q         <= head_q + BUF_DEPTH_WIDTH'(pop_cnt);
            tail_q         <= tail_q + BUF_DEPTH_WIDTH'(push_cnt);
            num_q          <= num_next;
            excep_first_q  <= alloc_first | alloc_second;
            excep_second_q <= alloc_first & alloc_second;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) entry_q[i] <= '0;
        end else begin
            if (push_first)
                entry_q[tail_q] <= port.commit_first_old_prd_i;
            if (push_second)
                entry_q[second_slot] <= port.commit_second_old_prd_i;
        end
    end

    assign port.commit_ready_o          = ready;
    assign port.fl_wr_first_en_o        = pop_first;
    assign port.fl_wr_second_en_o       = pop_second;
    assign port.fl_wdata_first_o        = pop_first  ? entry_q[head_q]     : '0;
    assign port.fl_wdata_second_o       = pop_second ? entry_q[head_plus1] : '0;
    assign port.fl_rd_excep_first_en_o  = excep_first_q;
    assign port.fl_rd_excep_second_en_o = excep_second_q;
    assign port.buf_num_o               = num_q;
    assign port.buf_empty_o             = (num_q == '0);
endmodule
